// File: rtl/gam_memory_bank_pkg.sv
// gam_memory_bank_pkg: op codes, mask bits and request/response records for the GAM memory bank
package gam_memory_bank_pkg;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_APPEND = 2'd2, OP_CLEAR = 2'd3} gam_mem_op_t;
  localparam int MSK_X = 0;
  localparam int MSK_C = 1;
  localparam int MSK_W = 2;
  localparam int MSK_T = 3;
  localparam int MSK_M = 4;
  localparam int GAM_NUM_CLASSES = 8;
  localparam int GAM_NODES_PER_CLASS = 16;
  localparam int GAM_DIM = 4;
  localparam int GAM_DATA_W = 16;
  localparam int GAM_SCAL_W = 32;
  localparam int GAM_CLS_W = $clog2(GAM_NUM_CLASSES);
  localparam int GAM_NODE_W = $clog2(GAM_NODES_PER_CLASS);
  typedef struct packed {
    logic [GAM_DIM-1:0][GAM_DATA_W-1:0] x;
    logic [GAM_DIM-1:0][GAM_DATA_W-1:0] w;
    logic [GAM_SCAL_W-1:0] th;
    logic [GAM_SCAL_W-1:0] m;
  } gam_node_t;
  typedef struct packed {
    gam_mem_op_t op;
    logic [4:0] mask;
    logic [GAM_CLS_W-1:0] cls;
    logic [GAM_NODE_W-1:0] node;
    gam_node_t data;
    logic [GAM_SCAL_W-1:0] cname;
  } gam_mem_req_t;
  typedef struct packed {
    logic err;
    logic [GAM_NODE_W-1:0] node;
    logic [GAM_NODE_W:0] count;
    gam_node_t data;
    logic [GAM_SCAL_W-1:0] cname;
  } gam_mem_resp_t;
endpackage

// File: rtl/gam_memory_bank_class_alloc.sv
// gam_class_alloc: per-class node counters with lookup, full flag, append and clear
module gam_class_alloc #(
  parameter int NUM_CLASSES = 8,
  parameter int NODES_PER_CLASS = 16,
  localparam int CLS_W = $clog2(NUM_CLASSES),
  localparam int NODE_W = $clog2(NODES_PER_CLASS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CLS_W-1:0]  cls,
  input  logic              inc,
  input  logic              clr,
  output logic [NODE_W:0]   count,
  output logic              full
);
  localparam logic [CLS_W:0] NCL = NUM_CLASSES[CLS_W:0];
  localparam logic [NODE_W:0] CAP = NODES_PER_CLASS[NODE_W:0];
  logic [NODE_W:0] cnt [NUM_CLASSES];
  logic ok;
  assign ok = {1'b0, cls} < NCL;
  assign count = ok ? cnt[cls] : '0;
  assign full = count == CAP;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
    else if (ok && clr) cnt[cls] <= '0;
    else if (ok && inc && !full) cnt[cls] <= count + CAP'(1);
endmodule

// File: rtl/gam_memory_bank.sv
// gam_memory_bank: handshaked per-class node store with append/clear allocation and error reporting
module gam_memory_bank import gam_memory_bank_pkg::*; #(
  parameter int NUM_CLASSES = 8,
  parameter int NODES_PER_CLASS = 16,
  parameter int DIM = 4,
  parameter int DATA_W = 16,
  parameter int SCAL_W = 32,
  localparam int CLS_W = $clog2(NUM_CLASSES),
  localparam int NODE_W = $clog2(NODES_PER_CLASS),
  localparam int VEC_W = DIM * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [4:0]        req_mask,
  input  logic [CLS_W-1:0]  req_class,
  input  logic [NODE_W-1:0] req_node,
  input  logic [VEC_W-1:0]  req_x,
  input  logic [VEC_W-1:0]  req_w,
  input  logic [SCAL_W-1:0] req_th,
  input  logic [SCAL_W-1:0] req_m,
  input  logic [SCAL_W-1:0] req_cname,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic [NODE_W-1:0] resp_node,
  output logic [NODE_W:0]   resp_count,
  output logic [VEC_W-1:0]  resp_x,
  output logic [VEC_W-1:0]  resp_w,
  output logic [SCAL_W-1:0] resp_th,
  output logic [SCAL_W-1:0] resp_m,
  output logic [SCAL_W-1:0] resp_cname
);
  localparam logic [CLS_W:0] NCL = NUM_CLASSES[CLS_W:0];
  gam_mem_op_t op;
  logic acc, cls_ok, full, err, rd, wr;
  logic [NODE_W:0] cnt;
  logic [NODE_W-1:0] widx;
  logic [VEC_W-1:0] mem_x [NUM_CLASSES][NODES_PER_CLASS];
  logic [VEC_W-1:0] mem_w [NUM_CLASSES][NODES_PER_CLASS];
  logic [SCAL_W-1:0] mem_th [NUM_CLASSES][NODES_PER_CLASS];
  logic [SCAL_W-1:0] mem_m [NUM_CLASSES][NODES_PER_CLASS];
  logic [SCAL_W-1:0] mem_c [NUM_CLASSES];
  assign op = gam_mem_op_t'(req_op);
  assign req_ready = !resp_valid || resp_ready;
  assign acc = req_valid && req_ready && !rst;
  assign cls_ok = {1'b0, req_class} < NCL;
  assign err = !cls_ok || ((op == OP_READ || op == OP_WRITE) && !({1'b0, req_node} < cnt)) || (op == OP_APPEND && full);
  assign rd = !err && op == OP_READ;
  assign wr = acc && !err && (op == OP_WRITE || op == OP_APPEND);
  assign widx = op == OP_APPEND ? cnt[NODE_W-1:0] : req_node;
  gam_class_alloc #(.NUM_CLASSES(NUM_CLASSES), .NODES_PER_CLASS(NODES_PER_CLASS)) u_alloc (
    .clk(clk),
    .rst(rst),
    .cls(req_class),
    .inc(acc && !err && op == OP_APPEND),
    .clr(acc && !err && op == OP_CLEAR),
    .count(cnt),
    .full(full)
  );
  // node storage is deliberately left unreset; the counters define which entries are live
  always_ff @(posedge clk)
    if (wr) begin
      if (req_mask[MSK_X]) mem_x[req_class][widx] <= req_x;
      if (req_mask[MSK_W]) mem_w[req_class][widx] <= req_w;
      if (req_mask[MSK_T]) mem_th[req_class][widx] <= req_th;
      if (req_mask[MSK_M]) mem_m[req_class][widx] <= req_m;
      if (req_mask[MSK_C]) mem_c[req_class] <= req_cname;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_node <= '0;
      resp_count <= '0;
      resp_x <= '0;
      resp_w <= '0;
      resp_th <= '0;
      resp_m <= '0;
      resp_cname <= '0;
    end else if (acc) begin
      resp_valid <= 1'b1;
      resp_err <= err;
      resp_node <= (err || op == OP_CLEAR) ? '0 : (op == OP_APPEND ? cnt[NODE_W-1:0] : req_node);
      resp_count <= err ? cnt : (op == OP_APPEND ? cnt + (NODE_W+1)'(1) : (op == OP_CLEAR ? '0 : cnt));
      resp_x <= (rd && req_mask[MSK_X]) ? mem_x[req_class][req_node] : '0;
      resp_w <= (rd && req_mask[MSK_W]) ? mem_w[req_class][req_node] : '0;
      resp_th <= (rd && req_mask[MSK_T]) ? mem_th[req_class][req_node] : '0;
      resp_m <= (rd && req_mask[MSK_M]) ? mem_m[req_class][req_node] : '0;
      resp_cname <= (rd && req_mask[MSK_C]) ? mem_c[req_class] : '0;
    end else if (resp_ready) resp_valid <= 1'b0;
endmodule

// File: tb/tb_gam_memory_bank.sv
// tb_gam_memory_bank: directed scoreboard bench for gam_memory_bank (6 classes to reach the class range check)
module tb_gam_memory_bank;
  localparam int NC = 6;
  typedef struct packed {
    logic err;
    logic [3:0] node;
    logic [4:0] count;
    logic [63:0] x;
    logic [63:0] w;
    logic [31:0] th;
    logic [31:0] m;
    logic [31:0] cn;
  } rsp_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, resp_valid, resp_ready = 1, resp_err;
  logic [1:0] req_op = 0;
  logic [4:0] req_mask = 0;
  logic [2:0] req_class = 0;
  logic [3:0] req_node = 0, resp_node;
  logic [4:0] resp_count;
  logic [63:0] req_x = 0, req_w = 0, resp_x, resp_w;
  logic [31:0] req_th = 0, req_m = 0, req_cname = 0, resp_th, resp_m, resp_cname;
  int n_chk = 0, n_fail = 0;
  rsp_t exp_q[$];
  string tag_q[$];
  logic [4:0] cnt_m [8];
  logic [63:0] mx [8][16];
  logic [63:0] mw [8][16];
  logic [31:0] mth [8][16];
  logic [31:0] mm [8][16];
  logic [31:0] mc [8];
  localparam logic [63:0] X1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] W1 = {16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [63:0] W9 = {16'd9, 16'd9, 16'd9, 16'd9};

  gam_memory_bank #(.NUM_CLASSES(NC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_mask(req_mask), .req_class(req_class), .req_node(req_node), .req_x(req_x), .req_w(req_w),
    .req_th(req_th), .req_m(req_m), .req_cname(req_cname), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_err(resp_err), .resp_node(resp_node), .resp_count(resp_count),
    .resp_x(resp_x), .resp_w(resp_w), .resp_th(resp_th), .resp_m(resp_m), .resp_cname(resp_cname)
  );

  always #5 clk = ~clk;

  function automatic rsp_t obs();
    return {resp_err, resp_node, resp_count, resp_x, resp_w, resp_th, resp_m, resp_cname};
  endfunction

  always @(negedge clk)
    if (!rst && resp_valid && resp_ready) begin
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_resp: observed %h expected none", obs());
      end
      if (exp_q.size() > 0) begin
        rsp_t e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_chk++;
        assert (obs() === e) else begin
          n_fail++;
          $error("FAIL %s: observed %h expected %h", t, obs(), e);
        end
      end
    end

  // reference behaviour of one accepted request
  task automatic model(input logic [1:0] op, input logic [4:0] mask, input logic [2:0] cls,
                       input logic [3:0] node, input logic [63:0] x, w, input logic [31:0] th, m, cn,
                       output rsp_t e);
    logic [4:0] c;
    logic er;
    logic [3:0] a;
    e = '0;
    c = (cls < NC) ? cnt_m[cls] : 5'd0;
    er = (cls >= NC) || (op < 2 && {1'b0, node} >= c) || (op == 2 && c == 5'd16);
    e.err = er;
    e.count = c;
    a = (op == 2) ? c[3:0] : node;
    if (!er) begin
      if (op == 0) begin
        e.node = node;
        if (mask[0]) e.x = mx[cls][node];
        if (mask[1]) e.cn = mc[cls];
        if (mask[2]) e.w = mw[cls][node];
        if (mask[3]) e.th = mth[cls][node];
        if (mask[4]) e.m = mm[cls][node];
      end else if (op == 3) begin
        cnt_m[cls] = 0;
        e.count = 0;
      end else begin
        e.node = a;
        if (mask[0]) mx[cls][a] = x;
        if (mask[1]) mc[cls] = cn;
        if (mask[2]) mw[cls][a] = w;
        if (mask[3]) mth[cls][a] = th;
        if (mask[4]) mm[cls][a] = m;
        if (op == 2) begin
          cnt_m[cls] = c + 5'd1;
          e.count = c + 5'd1;
        end
      end
    end
  endtask

  task automatic set_req(input logic [1:0] op, input logic [4:0] mask, input logic [2:0] cls,
                         input logic [3:0] node, input logic [63:0] x, w, input logic [31:0] th, m, cn);
    req_op = op; req_mask = mask; req_class = cls; req_node = node;
    req_x = x; req_w = w; req_th = th; req_m = m; req_cname = cn;
    req_valid = 1;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] mask, input logic [2:0] cls,
                      input logic [3:0] node, input logic [63:0] x, w, input logic [31:0] th, m, cn,
                      input string tag);
    int t;
    rsp_t e;
    set_req(op, mask, cls, node, x, w, th, m, cn);
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 50);
    n_chk++;
    assert (req_ready === 1'b1 && t == 1) else begin
      n_fail++;
      $error("FAIL accept_%s: req_ready %b after %0d cycles, expected 1 after 1", tag, req_ready, t);
    end
    @(posedge clk);
    model(op, mask, cls, node, x, w, th, m, cn, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1 req_valid = 0;
    n_chk++;
    assert (resp_valid === 1'b1) else begin
      n_fail++;
      $error("FAIL latency_%s: resp_valid %b expected 1", tag, resp_valid);
    end
  endtask

  initial begin
    rsp_t s;
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_chk++;
    assert (resp_valid === 1'b0 && req_ready === 1'b1 && obs() === '0) else begin
      n_fail++;
      $error("FAIL reset_state: valid %b ready %b resp %h expected 0/1/0", resp_valid, req_ready, obs());
    end
    @(posedge clk); #1;
    send(0, 5'h1F, 2, 0, 0, 0, 0, 0, 0, "read_empty");
    send(2, 5'h1F, 2, 0, X1, W1, 100, 1, 2, "append_c2");
    send(0, 5'h1F, 2, 0, 0, 0, 0, 0, 0, "read_c2_n0");
    send(0, 5'h1F, 2, 1, 0, 0, 0, 0, 0, "read_node_eq_count");
    send(0, 5'h00, 2, 0, 0, 0, 0, 0, 0, "read_mask0");
    send(1, 5'h00, 2, 0, W9, W9, 7, 7, 7, "write_mask0");
    send(0, 5'h1F, 2, 0, 0, 0, 0, 0, 0, "read_after_mask0_write");
    for (int i = 0; i < 16; i++)
      send(2, 5'h1F, 5, 0, {4{16'(i)}}, ~{4{16'(i)}}, 32'(i * 10), 32'(i), 5, $sformatf("append_c5_%0d", i));
    send(2, 5'h1F, 5, 0, X1, W1, 1, 1, 5, "append_full");
    send(0, 5'h1D, 5, 15, 0, 0, 0, 0, 0, "read_c5_n15");
    send(3, 5'h00, 5, 9, 0, 0, 0, 0, 0, "clear_c5");
    send(2, 5'h1F, 5, 0, W9, X1, 3, 4, 5, "append_after_clear");
    send(0, 5'h1F, 5, 0, 0, 0, 0, 0, 0, "read_c5_after_clear");
    send(2, 5'h1F, 1, 0, X1, W1, 100, 1, 1, "append_c1");
    send(1, 5'h04, 1, 0, 0, W9, 0, 0, 0, "write_c1_w");
    send(0, 5'h1F, 1, 0, 0, 0, 0, 0, 0, "read_c1_merged");
    send(0, 5'h1F, 6, 0, 0, 0, 0, 0, 0, "read_class6");
    send(2, 5'h1F, 7, 0, X1, W1, 1, 1, 7, "append_class7");
    send(3, 5'h00, 6, 0, 0, 0, 0, 0, 0, "clear_class6");
    @(posedge clk); #1;
    resp_ready = 0;
    send(0, 5'h1F, 2, 0, 0, 0, 0, 0, 0, "hold_a");
    set_req(0, 5'h1F, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    s = obs();
    repeat (3) begin
      n_chk++;
      assert (req_ready === 1'b0 && resp_valid === 1'b1 && obs() === s) else begin
        n_fail++;
        $error("FAIL hold_stable: ready %b valid %b resp %h expected 0/1/%h", req_ready, resp_valid, obs(), s);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    #1;
    n_chk++;
    assert (req_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL release_ready: req_ready %b expected 1", req_ready);
    end
    send(0, 5'h1F, 1, 0, 0, 0, 0, 0, 0, "hold_b");
    @(posedge clk); #1;
    resp_ready = 0;
    send(0, 5'h1F, 1, 0, 0, 0, 0, 0, 0, "dropped_by_reset");
    #2 rst = 1;
    #1;
    n_chk++;
    assert (resp_valid === 1'b0 && obs() === '0) else begin
      n_fail++;
      $error("FAIL async_reset: valid %b resp %h expected 0/0", resp_valid, obs());
    end
    exp_q.delete();
    tag_q.delete();
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    resp_ready = 1;
    send(0, 5'h1F, 1, 0, 0, 0, 0, 0, 0, "read_after_reset");
    send(2, 5'h1F, 1, 0, W1, X1, 5, 6, 1, "append_after_reset");
    send(0, 5'h1F, 1, 0, 0, 0, 0, 0, 0, "read_after_reset_append");
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
